prio_arbiter: RTL and testbench

PRIO_ARBITER -- requirements
Module: prio_arbiter

---
 rtl/prio_arbiter.sv | 102 ++++++++++
 tb/tb_prio_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/prio_arbiter.sv
// Priority arbiter with a one-deep registered output stage.
// MODE 0 grants the highest-index request; MODE 1 rotates priority downward from the last grant.
module prio_arbiter #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         req,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_idx,
  output logic [N-1:0]         out_onehot,
  output logic                 out_none
);

  localparam int W = $clog2(N);

  // Highest set bit wins; the all-zero vector yields index 0.
  function automatic logic [W-1:0] f_fixed_pick(input logic [N-1:0] r);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (r[i]) idx = W'(i);
    end
    return idx;
  endfunction

  // Scan last-1, last-2, ... wrapping to N-1, ending at last itself; first hit wins.
  function automatic logic [W-1:0] f_rr_pick(input logic [N-1:0] r, input logic [W-1:0] last);
    logic [W-1:0] idx;
    logic [W-1:0] cand;
    logic         found;
    int           c;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      c = int'(last) - k;
      if (c < 0) c = c + N;
      cand = W'(c);
      if (!found && r[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic logic [N-1:0] f_onehot(input logic [W-1:0] idx, input logic none);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return none ? '0 : (one << idx);
  endfunction

  logic         r_vld_p1;
  logic [W-1:0] r_idx_p1;
  logic [N-1:0] r_onehot_p1;
  logic         r_none_p1;
  logic [W-1:0] r_last;

  logic         w_accept;
  logic         w_none;
  logic [W-1:0] w_fix_idx;
  logic [W-1:0] w_rr_idx;
  logic [W-1:0] w_idx;

  assign in_ready  = !r_vld_p1 || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_none    = ~|req;
  assign w_fix_idx = f_fixed_pick(req);
  assign w_rr_idx  = f_rr_pick(req, r_last);
  assign w_idx     = w_none ? '0 : ((MODE == 1) ? w_rr_idx : w_fix_idx);

  // Stage p0 -> p1: capture the grant on accept, hold it under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1    <= 1'b0;
      r_idx_p1    <= '0;
      r_onehot_p1 <= '0;
      r_none_p1   <= 1'b0;
      r_last      <= '0;
    end else begin
      if (w_accept) begin
        r_vld_p1    <= 1'b1;
        r_idx_p1    <= w_idx;
        r_onehot_p1 <= f_onehot(w_idx, w_none);
        r_none_p1   <= w_none;
        if (MODE == 1 && !w_none) r_last <= w_idx;
      end else if (out_ready) begin
        r_vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid  = r_vld_p1;
  assign out_idx    = r_idx_p1;
  assign out_onehot = r_onehot_p1;
  assign out_none   = r_none_p1;

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench: fixed-priority and round-robin instances at N=4, plus a round-robin instance at N=3.
module tb_prio_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv0 = 1'b0, ir0, ov0, ordy0 = 1'b0, none0;
  logic [3:0] req0 = '0, oh0;
  logic [1:0] idx0;

  logic       iv1 = 1'b0, ir1, ov1, ordy1 = 1'b0, none1;
  logic [3:0] req1 = '0, oh1;
  logic [1:0] idx1;

  logic       iv2 = 1'b0, ir2, ov2, ordy2 = 1'b0, none2;
  logic [2:0] req2 = '0, oh2;
  logic [1:0] idx2;

  int checks = 0;
  int errors = 0;

  prio_arbiter #(.N(4), .MODE(0)) u_fix (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .req(req0),
    .out_valid(ov0), .out_ready(ordy0), .out_idx(idx0), .out_onehot(oh0), .out_none(none0));

  prio_arbiter #(.N(4), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .req(req1),
    .out_valid(ov1), .out_ready(ordy1), .out_idx(idx1), .out_onehot(oh1), .out_none(none1));

  prio_arbiter #(.N(3), .MODE(1)) u_rr3 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .req(req2),
    .out_valid(ov2), .out_ready(ordy2), .out_idx(idx2), .out_onehot(oh2), .out_none(none2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e_rr4 [5] = '{3, 2, 1, 0, 3};
    int e_rr3 [5] = '{2, 1, 0, 2, 1};

    // Reset state and reset dominance over a pending accept.
    #3;
    chk("rst_vld", ov0, 0);
    chk("rst_idx", idx0, 0);
    chk("rst_oh", oh0, 0);
    chk("rst_none", none0, 0);
    chk("rst_in_ready", ir0, 1);
    iv0 = 1'b1; req0 = 4'b1101; ordy0 = 1'b1;
    step;
    chk("rst_no_accept", ov0, 0);
    chk("rst_in_ready_edge", ir0, 1);
    #5 rst = 1'b0;

    // Fixed priority.
    step;
    chk("m0_1101_vld", ov0, 1);
    chk("m0_1101_idx", idx0, 3);
    chk("m0_1101_oh", oh0, 4'b1000);
    chk("m0_1101_none", none0, 0);
    req0 = 4'b0000;
    step;
    chk("m0_zero_none", none0, 1);
    chk("m0_zero_idx", idx0, 0);
    chk("m0_zero_oh", oh0, 4'b0000);
    chk("m0_zero_vld", ov0, 1);
    req0 = 4'b0001;
    step;
    chk("m0_0001_idx", idx0, 0);
    chk("m0_0001_none", none0, 0);
    chk("m0_0001_oh", oh0, 4'b0001);
    req0 = 4'b0110;
    step;
    chk("m0_0110_idx", idx0, 2);
    iv0 = 1'b0;
    step;
    chk("m0_drain_vld", ov0, 0);

    // Backpressure: result frozen, changed req ignored.
    iv0 = 1'b1; req0 = 4'b0010; ordy0 = 1'b0;
    step;
    chk("bp_first_vld", ov0, 1);
    chk("bp_first_idx", idx0, 1);
    req0 = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", ir0, 0);
      chk("bp_hold_vld", ov0, 1);
      chk("bp_hold_idx", idx0, 1);
      chk("bp_hold_oh", oh0, 4'b0010);
      step;
    end
    ordy0 = 1'b1;
    #1;
    chk("bp_release_in_ready", ir0, 1);
    step;
    chk("bp_new_vld", ov0, 1);
    chk("bp_new_idx", idx0, 3);
    chk("bp_new_oh", oh0, 4'b1000);
    iv0 = 1'b0;
    step;
    chk("bp_drain_vld", ov0, 0);

    // Round-robin rotation, N=4 and non-power-of-two N=3.
    iv1 = 1'b1; req1 = 4'b1111; ordy1 = 1'b1;
    iv2 = 1'b1; req2 = 3'b111;  ordy2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("rr4_seq_idx", idx1, e_rr4[i]);
      chk("rr4_seq_oh", oh1, 4'b0001 << e_rr4[i]);
      chk("rr3_seq_idx", idx2, e_rr3[i]);
      chk("rr3_seq_oh", oh2, 3'b001 << e_rr3[i]);
    end
    iv1 = 1'b0; iv2 = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rr_rst_vld", ov1, 0);
    #3 rst = 1'b0;

    // Round-robin: all-zero accept leaves the pointer alone.
    iv1 = 1'b1; req1 = 4'b1010;
    step;
    chk("rr_1010a_idx", idx1, 3);
    chk("rr_1010a_none", none1, 0);
    req1 = 4'b0000;
    step;
    chk("rr_zero_none", none1, 1);
    chk("rr_zero_idx", idx1, 0);
    chk("rr_zero_oh", oh1, 4'b0000);
    req1 = 4'b1010;
    step;
    chk("rr_1010b_idx", idx1, 1);
    chk("rr_1010b_oh", oh1, 4'b0010);

    // Drive pointer to 2, then reset asynchronously with a result pending.
    req1 = 4'b1111;
    step;
    chk("rr_ptr_a", idx1, 0);
    step;
    chk("rr_ptr_b", idx1, 3);
    step;
    chk("rr_ptr_c", idx1, 2);
    chk("rr_ptr_vld", ov1, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", ov1, 0);
    chk("arst_idx", idx1, 0);
    chk("arst_oh", oh1, 0);
    chk("arst_in_ready", ir1, 1);
    step;
    chk("arst_hold_vld", ov1, 0);
    #3 rst = 1'b0;
    step;
    chk("arst_after_vld", ov1, 1);
    chk("arst_after_idx", idx1, 3);
    iv1 = 1'b0;
    step;
    chk("arst_drain_vld", ov1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
